// File: rtl/bcd_to_binary_if.sv
// Handshake and data bundle between a digit-entry source and the BCD-to-binary converter.
interface bcd_to_binary_if;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [9:0] binary_value;
    logic [7:0] eight_bit_value;
    logic       overflow;
    logic       digit_error;

    // Requester side: issues digits and start, observes status and result
    modport master (
        output start, hundreds, tens, ones,
        input  busy, done, binary_value, eight_bit_value, overflow, digit_error
    );

    // Converter side
    modport slave (
        input  start, hundreds, tens, ones,
        output busy, done, binary_value, eight_bit_value, overflow, digit_error
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to binary converter using iterative reverse double-dabble.
// Ten shift iterations then a single finish cycle; illegal digits are rejected
// immediately from IDLE with a done/digit_error pulse and no conversion.
module bcd_to_binary (
    input  logic              clk,
    input  logic              reset,
    bcd_to_binary_if.slave    bus
);
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_W   = 3 * DIGIT_W;
    localparam int unsigned BIN_W   = 10;
    localparam int unsigned SAT_W   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WORD_W  = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_sr, bcd_sr_nxt;
    logic [BIN_W-1:0]   bin_sr, bin_sr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic [BIN_W-1:0]   bin_val_q, bin_val_nxt;
    logic [SAT_W-1:0]   sat_val_q, sat_val_nxt;
    logic               ovf_q, ovf_nxt;
    logic               derr_q, derr_nxt;

    logic               digits_ok_c;
    logic [WORD_W-1:0]  word_sh_c;
    logic [BCD_W-1:0]   bcd_fix_c;
    logic               over_c;

    // Subtract 3 from a digit that reached 8 or more after the right shift
    function automatic logic [DIGIT_W-1:0] fix_digit(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(8)) ? d - DIGIT_W'(3) : d;
    endfunction

    // Shift datapath and digit legality, shared by the FSM below
    always_comb begin
        digits_ok_c = (bus.hundreds <= DIGIT_W'(9)) &&
                      (bus.tens     <= DIGIT_W'(9)) &&
                      (bus.ones     <= DIGIT_W'(9));
        word_sh_c   = {bcd_sr, bin_sr} >> 1;
        bcd_fix_c   = {fix_digit(word_sh_c[WORD_W-1 -: DIGIT_W]),
                       fix_digit(word_sh_c[WORD_W-DIGIT_W-1 -: DIGIT_W]),
                       fix_digit(word_sh_c[BIN_W+DIGIT_W-1 -: DIGIT_W])};
        over_c      = (bin_sr > BIN_W'(255));
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        bcd_sr_nxt  = bcd_sr;
        bin_sr_nxt  = bin_sr;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        bin_val_nxt = bin_val_q;
        sat_val_nxt = sat_val_q;
        ovf_nxt     = ovf_q;
        derr_nxt    = derr_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (digits_ok_c) begin
                        bcd_sr_nxt = {bus.hundreds, bus.tens, bus.ones};
                        bin_sr_nxt = '0;
                        cnt_nxt    = '0;
                        state_nxt  = SHIFT;
                    end else begin
                        done_nxt = 1'b1;
                        derr_nxt = 1'b1;
                        ovf_nxt  = 1'b0;
                    end
                end
            end
            SHIFT: begin
                bcd_sr_nxt = bcd_fix_c;
                bin_sr_nxt = word_sh_c[BIN_W-1:0];
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(9)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                bin_val_nxt = bin_sr;
                sat_val_nxt = over_c ? SAT_W'(255) : bin_sr[SAT_W-1:0];
                ovf_nxt     = over_c;
                derr_nxt    = 1'b0;
                done_nxt    = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bcd_sr    <= '0;
            bin_sr    <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_val_q <= '0;
            sat_val_q <= '0;
            ovf_q     <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bcd_sr    <= bcd_sr_nxt;
            bin_sr    <= bin_sr_nxt;
            cnt       <= cnt_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            bin_val_q <= bin_val_nxt;
            sat_val_q <= sat_val_nxt;
            ovf_q     <= ovf_nxt;
            derr_q    <= derr_nxt;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.binary_value    = bin_val_q;
    assign bus.eight_bit_value = sat_val_q;
    assign bus.overflow        = ovf_q;
    assign bus.digit_error     = derr_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_bcd_to_binary;
    logic clk = 1'b0;
    logic reset;

    typedef struct packed {
        logic [9:0] bin;
        logic [7:0] sat;
        logic       ovf;
        logic       derr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bcd_to_binary_if bus ();

    bcd_to_binary dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expected entry
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("binary_value",    int'(bus.binary_value),    int'(e.bin));
                check("eight_bit_value", int'(bus.eight_bit_value), int'(e.sat));
                check("overflow",        int'(bus.overflow),        int'(e.ovf));
                check("digit_error",     int'(bus.digit_error),     int'(e.derr));
            end
        end
    end

    task automatic set_digits(input int h, input int t, input int o);
        bus.hundreds = 4'(h);
        bus.tens     = 4'(t);
        bus.ones     = 4'(o);
    endtask

    // Full valid conversion with latency and busy-width checks
    task automatic convert(input int h, input int t, input int o,
                           input int bin, input int sat, input int ovf);
        int busy_cnt;
        int lat;
        exp_t e;
        e = '{bin: 10'(bin), sat: 8'(sat), ovf: 1'(ovf), derr: 1'b0};
        @(negedge clk);
        set_digits(h, t, o);
        bus.start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        busy_cnt = 0;
        lat = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = cyc;
                check("busy_in_done_cycle", int'(bus.busy), 0);
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
        end
        check("done_latency", lat, 11);
        check("busy_cycles", busy_cnt, 11);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_bin"},  int'(bus.binary_value), 0);
        check({tag, "_sat"},  int'(bus.eight_bit_value), 0);
        check({tag, "_ovf"},  int'(bus.overflow), 0);
        check({tag, "_derr"}, int'(bus.digit_error), 0);
    endtask

    task automatic count_no_done(input string name, input int ncyc);
        int dn;
        dn = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        check(name, dn, 0);
    endtask

    initial begin
        int lat;
        int busy_seen;
        exp_t e;

        reset = 1'b1;
        bus.start = 1'b0;
        set_digits(0, 0, 0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        convert(2, 3, 4, 234, 234, 0);
        convert(9, 9, 9, 999, 255, 1);
        convert(2, 5, 5, 255, 255, 0);
        convert(2, 5, 6, 256, 255, 1);
        convert(0, 0, 0, 0, 0, 0);
        convert(1, 4, 9, 149, 149, 0);

        // Illegal digit: immediate done with error, previous result held
        @(negedge clk);
        set_digits(1, 10, 0);
        bus.start = 1'b1;
        e = '{bin: 10'd149, sat: 8'd149, ovf: 1'b0, derr: 1'b1};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("illegal_done", int'(bus.done), 1);
        check("illegal_busy0", int'(bus.busy), 0);
        @(negedge clk);
        check("illegal_done_pulse", int'(bus.done), 0);
        check("illegal_busy1", int'(bus.busy), 0);

        // Start while busy with digit change mid-conversion
        @(negedge clk);
        set_digits(0, 1, 0);
        bus.start = 1'b1;
        e = '{bin: 10'd10, sat: 8'd10, ovf: 1'b0, derr: 1'b0};
        exp_q.push_back(e);
        @(posedge clk);
        lat = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == 3) ? 1'b1 : 1'b0;
            if (cyc == 3) set_digits(7, 6, 9);
            if (bus.done === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        check("busy_start_latency", lat, 11);
        count_no_done("no_second_done", 15);

        // Reset during the fifth shift iteration aborts the conversion
        @(negedge clk);
        set_digits(7, 6, 9);
        bus.start = 1'b1;
        @(posedge clk);
        busy_seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_seen++;
            if (cyc == 4) reset = 1'b1;
        end
        check("pre_reset_busy", busy_seen, 5);
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("abort");
        count_no_done("no_done_after_abort", 15);

        convert(7, 6, 9, 769, 255, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
